pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max consecutive MEM_WAIT cycles without dmem_ready_i before ERROR.
REQ-002 Parameter CNT_WIDTH, default 16: width of stall_count_o.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 id_rs_i  in  5  rs field of instruction in ID.
REQ-006 id_rt_i  in  5  rt field of instruction in ID.
REQ-007 idex_mem_read_i  in  1  instruction in EX is a load.
REQ-008 idex_rt_i  in  5  destination register of load in EX.
REQ-009 branch_taken_i  in  1  branch/jump in EX resolved taken.
REQ-010 dmem_req_i  in  1  MEM-stage data memory access active.
REQ-011 dmem_ready_i  in  1  data memory completes access this cycle.
REQ-012 pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o, memwb_enable_o  out  1 each  pipeline register enables.
REQ-013 ifid_flush_o, idex_flush_o, memwb_flush_o  out  1 each  load bubble (zeros) into that register at next edge.
REQ-014 state_o  out  2  current state: RUN=0, MEM_WAIT=2, ERROR=3 (1 unused).
REQ-015 stall_count_o  out  CNT_WIDTH  cycles with pc_enable_o=0 since reset, saturating.
REQ-016 error_o  out  1  sticky memory-timeout flag.

Function
REQ-017 Control outputs combinational from registered state and current inputs; state, wait counter, stall_count_o, error_o registered.
REQ-018 Default (RUN, no event): all enables 1, all flushes 0.
REQ-019 Load-use hazard = idex_mem_read_i & idex_rt_i!=0 & (idex_rt_i==id_rs_i | idex_rt_i==id_rt_i).
REQ-020 RUN priority, highest first: memory stall, branch flush, load-use stall.
REQ-021 Memory stall: RUN with dmem_req_i=1 & dmem_ready_i=0 -> all enables 0, memwb_flush_o=1, other flushes 0; next state MEM_WAIT, wait counter <= 1.
REQ-022 Branch flush: branch_taken_i=1 -> ifid_flush_o=1, idex_flush_o=1, all enables 1; load-use ignored that cycle.
REQ-023 Load-use stall: pc_enable_o=0, ifid_enable_o=0, idex_flush_o=1, remaining enables 1; single cycle, no state change.
REQ-024 dmem_req_i=1 & dmem_ready_i=1 in RUN: no stall.
REQ-025 MEM_WAIT, dmem_ready_i=0, wait counter < MEM_TIMEOUT: outputs as REQ-021, counter +1, branch/load-use suppressed.
REQ-026 MEM_WAIT, dmem_ready_i=1: release cycle; outputs per RUN rules REQ-022/023 (memory stall term false); next state RUN; counter <= 0.
REQ-027 MEM_WAIT, dmem_ready_i=0, counter == MEM_TIMEOUT: outputs as REQ-021; next state ERROR; error_o <= 1.
REQ-028 ERROR: all enables 0, memwb_flush_o=1; held until reset regardless of inputs.
REQ-029 stall_count_o increments on every edge where pc_enable_o=0 (reset low); holds at 2^CNT_WIDTH-1.

Reset
REQ-030 reset=1 at an edge: state<=RUN, wait counter<=0, stall_count_o<=0, error_o<=0, from any state incl. mid-MEM_WAIT and ERROR.
REQ-031 While reset=1: all enables 0, all flushes 0, and REQ-029 counting inhibited.
REQ-032 First cycle after reset release behaves as RUN.

Verification
REQ-033 Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 one cycle -> pc/ifid enable 0, idex_flush 1; stall_count 0->1; same with idex_rt=0 -> no stall.
REQ-034 Branch+load-use same cycle: branch_taken=1, hazard true -> ifid_flush=1, idex_flush=1, pc_enable=1, stall_count unchanged.
REQ-035 Memory wait: dmem_req=1, ready low 3 cycles then high -> 3 cycles all enables 0/memwb_flush 1, state_o=2 cycles 2-3, release cycle enables 1, state_o=0 after, stall_count=3.
REQ-036 Timeout: MEM_TIMEOUT=4, dmem_req=1, ready never -> ERROR after 5 stalled cycles, error_o=1, state_o=3, persists with ready=1 later.
REQ-037 Reset mid-MEM_WAIT and from ERROR -> next cycle state_o=0, error_o=0, stall_count_o=0, default outputs.
REQ-038 Saturation: CNT_WIDTH=3, 9 stall cycles -> stall_count_o holds 7.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a 5-stage pipeline: load-use interlock, taken-branch
// flush and data-memory wait handling with a timeout that latches a sticky error.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs_i,
  input  logic [4:0]           id_rt_i,
  input  logic                 idex_mem_read_i,
  input  logic [4:0]           idex_rt_i,
  input  logic                 branch_taken_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_ready_i,
  output logic                 pc_enable_o,
  output logic                 ifid_enable_o,
  output logic                 idex_enable_o,
  output logic                 exmem_enable_o,
  output logic                 memwb_enable_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 memwb_flush_o,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_count_o,
  output logic                 error_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0]    WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [WAIT_W-1:0]      wait_reg, wait_next;
  logic [CNT_WIDTH-1:0]   stall_reg, stall_next;
  logic                   error_reg, error_next;
  logic                   load_use;
  logic                   mem_stall;

  assign load_use = idex_mem_read_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    error_next = error_reg;
    mem_stall  = 1'b0;

    case (state_reg)
      RUN: begin
        if (dmem_req_i && !dmem_ready_i) begin
          mem_stall  = 1'b1;
          state_next = MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_next = RUN;
          wait_next  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wait_reg >= WAIT_LIMIT) begin
            state_next = ERROR;
            error_next = 1'b1;
          end else begin
            wait_next = wait_reg + 1'b1;
          end
        end
      end
      ERROR:   mem_stall = 1'b1;
      default: state_next = RUN;
    endcase

    pc_enable_o    = 1'b1;
    ifid_enable_o  = 1'b1;
    idex_enable_o  = 1'b1;
    exmem_enable_o = 1'b1;
    memwb_enable_o = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    memwb_flush_o  = 1'b0;

    // Memory stall outranks the branch flush, which in turn hides a load-use hit.
    if (reset) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_enable_o = 1'b0;
    end else if (mem_stall) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_enable_o = 1'b0;
      memwb_flush_o  = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (load_use) begin
      pc_enable_o   = 1'b0;
      ifid_enable_o = 1'b0;
      idex_flush_o  = 1'b1;
    end

    stall_next = stall_reg;
    if (!reset && !pc_enable_o && (stall_reg != CNT_MAX)) begin
      stall_next = stall_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      wait_reg  <= '0;
      stall_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      stall_reg <= stall_next;
      error_reg <= error_next;
    end
  end

  assign state_o       = state_reg;
  assign stall_count_o = stall_reg;
  assign error_o       = error_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: two controller instances (short timeout / narrow counter, and
// defaults) share randomized stimulus and are checked against a behavioural model.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic       idex_mem_read = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;

  logic       a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fmemwb, a_err;
  logic [1:0] a_state;
  logic [2:0] a_cnt;
  logic       b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fmemwb, b_err;
  logic [1:0] b_state;
  logic [15:0] b_cnt;

  pipeline_hazard_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) dut_a (
    .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_enable_o(a_pc), .ifid_enable_o(a_ifid), .idex_enable_o(a_idex),
    .exmem_enable_o(a_exmem), .memwb_enable_o(a_memwb),
    .ifid_flush_o(a_fifid), .idex_flush_o(a_fidex), .memwb_flush_o(a_fmemwb),
    .state_o(a_state), .stall_count_o(a_cnt), .error_o(a_err)
  );

  pipeline_hazard_controller dut_b (
    .clk(clk), .reset(reset), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt), .branch_taken_i(branch_taken),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_enable_o(b_pc), .ifid_enable_o(b_ifid), .idex_enable_o(b_idex),
    .exmem_enable_o(b_exmem), .memwb_enable_o(b_memwb),
    .ifid_flush_o(b_fifid), .idex_flush_o(b_fidex), .memwb_flush_o(b_fmemwb),
    .state_o(b_state), .stall_count_o(b_cnt), .error_o(b_err)
  );

  // Model mode: 0 running, 2 waiting on memory, 3 timed out.
  typedef struct {
    int mode;
    int waited;
    int stalls;
    bit err;
  } mdl_t;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [1:0]  st;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  mdl_t ma = '{0, 0, 0, 1'b0};
  mdl_t mb = '{0, 0, 0, 1'b0};
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  function automatic exp_t predict(input mdl_t m, input int tmo, input int cnt_max,
                                   output mdl_t n);
    exp_t       e;
    logic [4:0] en = 5'b11111;
    logic [2:0] fl = 3'b000;
    bit         stalled;
    bit         hazard;
    hazard = idex_mem_read && (idex_rt != 0) && (idex_rt == id_rs || idex_rt == id_rt);
    e.st  = m.mode[1:0];
    e.err = m.err;
    e.cnt = m.stalls[15:0];
    n = m;
    if (reset) begin
      en = 5'b00000;
      n  = '{0, 0, 0, 1'b0};
    end else begin
      stalled = (m.mode == 3) || (m.mode == 2 && !dmem_ready) ||
                (m.mode == 0 && dmem_req && !dmem_ready);
      if (stalled) begin
        en = 5'b00000; fl = 3'b001;
      end else if (branch_taken) begin
        fl = 3'b110;
      end else if (hazard) begin
        en = 5'b00111; fl = 3'b010;
      end
      if (m.mode == 0 && stalled) begin
        n.mode = 2; n.waited = 1;
      end else if (m.mode == 2 && !dmem_ready) begin
        if (m.waited == tmo) begin
          n.mode = 3; n.err = 1'b1;
        end else begin
          n.waited = m.waited + 1;
        end
      end else if (m.mode == 2) begin
        n.mode = 0; n.waited = 0;
      end
      if (en[4] == 1'b0 && m.stalls < cnt_max) n.stalls = m.stalls + 1;
    end
    e.ctrl = {en, fl};
    return e;
  endfunction

  task automatic drive(input bit r, input int rs, input int rt, input bit mr, input int irt,
                       input bit br, input bit rq, input bit rd);
    mdl_t n;
    @(posedge clk);
    #1;
    cycle++;
    reset = r; id_rs = 5'(rs); id_rt = 5'(rt); idex_mem_read = mr; idex_rt = 5'(irt);
    branch_taken = br; dmem_req = rq; dmem_ready = rd;
    qa.push_back(predict(ma, 4, 7, n));
    ma = n;
    qb.push_back(predict(mb, 15, 65535, n));
    mb = n;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual=%0h expected=%0h", nm, cycle, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("a_ctrl", {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fmemwb}, e.ctrl);
        chk("a_state", a_state, e.st);
        chk("a_error", a_err, e.err);
        chk("a_count", a_cnt, e.cnt);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("b_ctrl", {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fmemwb}, e.ctrl);
        chk("b_state", b_state, e.st);
        chk("b_error", b_err, e.err);
        chk("b_count", b_cnt, e.cnt);
      end
    end
  end

  initial begin : stimulus
    int prdy;
    int budget;
    // reset, load-use hit, rt=0 miss, branch over load-use
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 5, 0, 1, 5, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 7, 7, 1, 7, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // three-cycle memory wait then release
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // timeout on both instances, then ready arrives
    repeat (20) drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a memory wait
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(0, 3))
        0:       prdy = 0;
        1:       prdy = 10;
        2:       prdy = 50;
        default: prdy = 90;
      endcase
      if ($urandom_range(0, 1) == 1) drive(1, 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 40; c++) begin
        drive($urandom_range(0, 99) == 0,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3),
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 99) < prdy);
      end
    end

    budget = 0;
    while ((qa.size() != 0 || qb.size() != 0) && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", qa.size() + qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
